// File: rtl/id_issue_stage.sv
// ID-stage issue control: tracks the two in-flight writers (EX, MEM), detects
// load-use and branch-operand hazards, and drives the ID/EX register and stall/flush controls.
module id_issue_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic [RA_W-1:0]   id_dest,
  input  logic              id_writes,
  input  logic              id_is_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_data1,
  input  logic [DATA_W-1:0] id_data2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              ex_hold,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_writes,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_STALL_LU = 2'd1;
  localparam logic [1:0] ST_STALL_BR = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  logic [1:0]      state;
  logic [1:0]      next_state;
  logic            ex_is_load;
  logic            mem_valid;
  logic            mem_writes;
  logic            mem_is_load;
  logic [RA_W-1:0] mem_dest;

  logic m_ex_rs, m_ex_rt, m_mem_rs, m_mem_rt;
  logic load_use, branch_haz, stall;

  always_comb begin
    m_ex_rs  = ex_valid  & ex_writes  & id_uses_rs & (id_rs != '0) & (ex_dest  == id_rs);
    m_ex_rt  = ex_valid  & ex_writes  & id_uses_rt & (id_rt != '0) & (ex_dest  == id_rt);
    m_mem_rs = mem_valid & mem_writes & id_uses_rs & (id_rs != '0) & (mem_dest == id_rs);
    m_mem_rt = mem_valid & mem_writes & id_uses_rt & (id_rt != '0) & (mem_dest == id_rt);

    load_use   = id_valid & ex_is_load & (m_ex_rs | m_ex_rt);
    branch_haz = id_valid & id_is_branch &
                 ((m_ex_rs | m_ex_rt) | (mem_is_load & (m_mem_rs | m_mem_rt)));

    if (ex_hold)         next_state = ST_HOLD;
    else if (load_use)   next_state = ST_STALL_LU;
    else if (branch_haz) next_state = ST_STALL_BR;
    else                 next_state = ST_RUN;

    stall      = (next_state != ST_RUN);
    stall_pc   = stall;
    stall_ifid = stall;
    flush_ifid = id_valid & id_branch_taken & ~stall;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_RUN;
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_data1     <= '0;
      ex_data2     <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_writes    <= 1'b0;
      ex_is_load   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_writes   <= 1'b0;
      mem_is_load  <= 1'b0;
      mem_dest     <= '0;
      stall_cycles <= '0;
      bubble_count <= '0;
    end else begin
      state <= next_state;
      if (next_state == ST_HOLD) begin
        mem_valid   <= 1'b0;
        mem_writes  <= 1'b0;
        mem_is_load <= 1'b0;
        mem_dest    <= '0;
      end else begin
        mem_valid   <= ex_valid;
        mem_writes  <= ex_writes;
        mem_is_load <= ex_is_load;
        mem_dest    <= ex_dest;
      end
      case (next_state)
        ST_RUN: begin
          ex_valid   <= id_valid;
          ex_ctrl    <= id_ctrl;
          ex_data1   <= id_data1;
          ex_data2   <= id_data2;
          ex_imm     <= id_imm;
          ex_dest    <= id_dest;
          ex_writes  <= id_writes;
          ex_is_load <= id_is_load;
        end
        ST_STALL_LU, ST_STALL_BR: begin
          ex_valid   <= 1'b0;
          ex_ctrl    <= '0;
          ex_data1   <= '0;
          ex_data2   <= '0;
          ex_imm     <= '0;
          ex_dest    <= '0;
          ex_writes  <= 1'b0;
          ex_is_load <= 1'b0;
          if (bubble_count != '1) bubble_count <= bubble_count + 1'b1;
        end
        default: ;
      endcase
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // A cycle spent in a hazard stall always leaves a bubble in ID/EX.
  always_ff @(posedge Clock) begin
    if (!Reset && (state == ST_STALL_LU || state == ST_STALL_BR))
      assert (!ex_valid);
  end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: load-use, branch hazards, hold, $0, flush,
// counter saturation (CNT_W=4) and reset abort.
module tb_id_issue_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic        id_writes, id_is_load;
  logic [15:0] id_ctrl;
  logic [31:0] id_data1, id_data2, id_imm;
  logic        ex_hold;
  logic        ex_valid, ex_writes, stall_pc, stall_ifid, flush_ifid;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic [4:0]  ex_dest;
  logic [3:0]  stall_cycles, bubble_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  id_issue_stage #(.DATA_W(32), .RA_W(5), .CTRL_W(16), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .id_dest(id_dest), .id_writes(id_writes), .id_is_load(id_is_load),
    .id_ctrl(id_ctrl), .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_data1(ex_data1), .ex_data2(ex_data2),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_writes(ex_writes),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Payload is derived from dest so issued bundles are recognisable in EX.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br, input logic tk, input logic [4:0] dest,
                       input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    id_is_branch = br; id_branch_taken = tk; id_dest = dest;
    id_writes = wr; id_is_load = ld;
    id_ctrl  = 16'hA000 | {11'h0, dest};
    id_data1 = 32'h1000_0000 | {27'h0, dest};
    id_data2 = 32'h2000_0000 | {27'h0, dest};
    id_imm   = 32'h3000_0000 | {27'h0, dest};
    #1;
  endtask

  initial begin
    Reset = 1'b1; ex_hold = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    Reset = 1'b0;
    #1;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 0);
    check("rst_stall", stall_pc, 0);
    check("rst_flush", flush_ifid, 0);
    check("rst_cnt", {stall_cycles, bubble_count}, 0);

    // load-use: lw $8 then add $10,$8,$2
    drive(1, 1, 0, 0, 0, 8, 1, 1);
    check("lw_nostall", stall_pc, 0);
    tick();
    check("lw_ex_valid", ex_valid, 1);
    check("lw_ex_dest", ex_dest, 8);
    check("lw_ex_data1", ex_data1, 32'h1000_0008);
    drive(1, 8, 2, 0, 0, 10, 1, 0);
    check("lu_stall_pc", stall_pc, 1);
    check("lu_stall_ifid", stall_ifid, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", ex_ctrl, 0);
    check("lu_bubble_cnt", bubble_count, 1);
    check("lu_stall_cnt", stall_cycles, 1);
    check("lu_resolved", stall_pc, 0);
    tick();
    check("add_issued", ex_valid, 1);
    check("add_dest", ex_dest, 10);

    // branch on EX ALU result: beq $10 taken
    drive(1, 10, 0, 1, 1, 0, 0, 0);
    check("br_alu_stall", stall_pc, 1);
    check("br_alu_noflush", flush_ifid, 0);
    tick();
    check("br_alu_bubble", bubble_count, 2);
    check("br_alu_resolved", stall_pc, 0);
    check("br_alu_flush", flush_ifid, 1);
    tick();
    check("br_alu_issued", ex_ctrl, 16'hA000);

    // branch on EX load: two stall cycles
    drive(1, 0, 0, 0, 0, 9, 1, 1);
    tick();
    drive(1, 9, 0, 1, 0, 0, 0, 0);
    check("br_ld_stall1", stall_pc, 1);
    tick();
    check("br_ld_stall2", stall_pc, 1);
    tick();
    check("br_ld_resolved", stall_pc, 0);
    check("br_ld_stall_cnt", stall_cycles, 4);
    check("br_ld_bubble_cnt", bubble_count, 4);
    tick();
    check("br_ld_issued", ex_valid, 1);

    // $0 never hazards; taken jump flushes same cycle
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0);
    check("r0_nostall", stall_pc, 0);
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    check("r0_jump_nostall", stall_pc, 0);
    check("r0_jump_flush", flush_ifid, 1);
    tick();

    // hold: lw $11, lw $12, then 3 hold cycles with a load-use pending in ID
    drive(1, 0, 0, 0, 0, 11, 1, 1);
    tick();
    drive(1, 0, 0, 0, 0, 12, 1, 1);
    tick();
    ex_hold = 1'b1;
    drive(1, 12, 0, 0, 0, 13, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_stall", stall_pc, 1);
      check("hold_noflush", flush_ifid, 0);
      tick();
      check("hold_ex_valid", ex_valid, 1);
      check("hold_ex_dest", ex_dest, 12);
      check("hold_ex_imm", ex_imm, 32'h3000_000C);
      check("hold_bubble_cnt", bubble_count, 4);
    end
    check("hold_stall_cnt", stall_cycles, 7);
    ex_hold = 1'b0;
    // MEM was cleared by hold, so a branch on $11 sees no hazard
    drive(1, 11, 0, 1, 1, 0, 0, 0);
    check("hold_mem_clear", stall_pc, 0);
    check("hold_mem_flush", flush_ifid, 1);
    tick();

    // saturation
    ex_hold = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_cnt", stall_cycles, 15);

    // reset during hold
    Reset = 1'b1;
    tick();
    Reset = 1'b0; ex_hold = 1'b0;
    #1;
    check("rst2_ex_valid", ex_valid, 0);
    check("rst2_ex_data1", ex_data1, 0);
    check("rst2_stall", stall_pc, 0);
    check("rst2_flush", flush_ifid, 0);
    check("rst2_cnt", {stall_cycles, bubble_count}, 0);
    tick();
    check("rst2_no_residual", stall_ifid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
